// File: rtl/btn_script_player_if.sv
// Control, programming and button-drive signals of btn_script_player.
// master = controller/bench side, slave = the player.
interface btn_script_player_if #(
  parameter int N_CH   = 3,
  parameter int DUR_W  = 16,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              stop;
  logic              loop_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [N_CH-1:0]   wr_mask;
  logic [DUR_W-1:0]  wr_dur;
  logic [N_CH-1:0]   live_btn;
  logic [N_CH-1:0]   btn_out;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] step_idx;

  modport master (
    output start, stop, loop_en, wr_en, wr_addr, wr_mask, wr_dur, live_btn,
    input  btn_out, busy, done, step_idx
  );

  modport slave (
    input  start, stop, loop_en, wr_en, wr_addr, wr_mask, wr_dur, live_btn,
    output btn_out, busy, done, step_idx
  );
endinterface

// File: rtl/btn_script_player.sv
// Replays a programmable list of (button mask, hold ticks) entries onto N_CH button lines.
// Optional feature macro SCRIPT_LIVE_OR_EN: OR synchronized live buttons into btn_out.
module btn_script_player #(
  parameter int N_CH     = 3,
  parameter int DEPTH    = 16,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 1
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  btn_script_player_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [DUR_W-1:0]  DUR_ZERO = {DUR_W{1'b0}};
  localparam logic [DUR_W-1:0]  CNT_ONE  = DUR_W'(1'b1);
  localparam logic [PRE_W-1:0]  PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1'b1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [N_CH-1:0]   MASK_ZERO = {N_CH{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  logic [N_CH-1:0]   mem_mask_r [DEPTH];
  logic [DUR_W-1:0]  mem_dur_r  [DEPTH];

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] idx_r, idx_s;
  logic [DUR_W-1:0]  cnt_r, cnt_s;
  logic [PRE_W-1:0]  pre_r, pre_s;
  logic [N_CH-1:0]   btn_r, btn_s;
  logic              busy_r;
  logic              done_r, done_s;
  logic              ld_s;
  logic [ADDR_W-1:0] ld_idx_s;
  logic [ADDR_W-1:0] nxt_idx_s;
  logic              tick_s;

  // Script storage: cleared on reset, written whenever wr_en is high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_mask_r[i] <= MASK_ZERO;
        mem_dur_r[i]  <= DUR_ZERO;
      end
    end else if (bus.wr_en) begin
      mem_mask_r[bus.wr_addr] <= bus.wr_mask;
      mem_dur_r[bus.wr_addr]  <= bus.wr_dur;
    end
  end

  // Next-state logic; an entry load latches its mask and duration so later writes don't disturb it.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    cnt_s     = cnt_r;
    pre_s     = pre_r;
    btn_s     = btn_r;
    done_s    = 1'b0;
    ld_s      = 1'b0;
    ld_idx_s  = IDX_ZERO;
    nxt_idx_s = idx_r + IDX_ONE;
    tick_s    = (pre_r == PRE_LAST);

    if (bus.stop) begin
      state_s = ST_IDLE;
      idx_s   = IDX_ZERO;
      cnt_s   = DUR_ZERO;
      pre_s   = PRE_ZERO;
      btn_s   = MASK_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            if (mem_dur_r[IDX_ZERO] != DUR_ZERO) begin
              ld_s = 1'b1;
            end else begin
              done_s = 1'b1;
            end
          end else begin
            done_s = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!tick_s) begin
            pre_s = pre_r + PRE_ONE;
          end else if (cnt_r != CNT_ONE) begin
            pre_s = PRE_ZERO;
            cnt_s = cnt_r - CNT_ONE;
          end else if ((idx_r != IDX_LAST) && (mem_dur_r[nxt_idx_s] != DUR_ZERO)) begin
            ld_s     = 1'b1;
            ld_idx_s = nxt_idx_s;
          end else if (bus.loop_en && (mem_dur_r[IDX_ZERO] != DUR_ZERO)) begin
            ld_s = 1'b1;
          end else begin
            // End of script; a looping run with an emptied entry 0 just stops quietly.
            state_s = ST_IDLE;
            idx_s   = IDX_ZERO;
            cnt_s   = DUR_ZERO;
            pre_s   = PRE_ZERO;
            btn_s   = MASK_ZERO;
            done_s  = ~bus.loop_en;
          end
        end
        default: begin
          state_s = ST_IDLE;
          idx_s   = IDX_ZERO;
          cnt_s   = DUR_ZERO;
          pre_s   = PRE_ZERO;
          btn_s   = MASK_ZERO;
        end
      endcase
    end

    if (ld_s) begin
      state_s = ST_HOLD;
      idx_s   = ld_idx_s;
      cnt_s   = mem_dur_r[ld_idx_s];
      pre_s   = PRE_ZERO;
      btn_s   = mem_mask_r[ld_idx_s];
    end else begin
      ld_idx_s = ld_idx_s;
    end
  end

  // Player state and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= IDX_ZERO;
      cnt_r   <= DUR_ZERO;
      pre_r   <= PRE_ZERO;
      btn_r   <= MASK_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      pre_r   <= pre_s;
      btn_r   <= btn_s;
      busy_r  <= (state_s == ST_HOLD);
      done_r  <= done_s;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.step_idx = idx_r;

`ifdef SCRIPT_LIVE_OR_EN
  logic [1:0][N_CH-1:0] live_sync_r;

  // Two-flop synchronizer for the asynchronous physical buttons.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      live_sync_r <= {2{MASK_ZERO}};
    end else begin
      live_sync_r <= {live_sync_r[0], bus.live_btn};
    end
  end

  assign bus.btn_out = btn_r | live_sync_r[1];
`else
  logic [N_CH-1:0] unused_live_s;
  assign unused_live_s = bus.live_btn;
  assign bus.btn_out   = btn_r;
`endif
endmodule

// File: tb/tb_btn_script_player.sv
// Self-checking bench for btn_script_player: vector table, hand-written corner sequences
// and randomized scripts checked against a trace expanded from the script contents.
module tb_btn_script_player;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [2:0] btn;
    logic       busy;
    logic       done;
    logic [3:0] idx;
  } obs_t;

  typedef struct packed {
    logic start;
    logic stop;
    obs_t exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_script_player_if #(.N_CH(3), .DUR_W(16), .ADDR_W(4)) bus  ();
  btn_script_player_if #(.N_CH(3), .DUR_W(8),  .ADDR_W(2)) bus4 ();

  btn_script_player #(.N_CH(3), .DEPTH(16), .DUR_W(16), .TICK_DIV(1)) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus)
  );

  btn_script_player #(.N_CH(3), .DEPTH(4), .DUR_W(8), .TICK_DIV(4)) u_dut4 (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus4)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0]  m_mask [DEPTH];
  logic [15:0] m_dur  [DEPTH];
  obs_t        exp_q  [$];
  vec_t        tbl    [$];

  function automatic obs_t mk(input logic [2:0] b, input logic bz, input logic d, input logic [3:0] i);
    obs_t o;
    o.btn = b; o.busy = bz; o.done = d; o.idx = i;
    return o;
  endfunction

  function automatic vec_t mv(input logic s, input logic p, input obs_t e);
    vec_t v;
    v.start = s; v.stop = p; v.exp = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_vals(input string tag, input logic [2:0] b, input logic bz, input logic d,
                          input logic [3:0] i, input obs_t e);
    chk({tag, ".btn_out"},  32'(b),  32'(e.btn));
    chk({tag, ".busy"},     32'(bz), 32'(e.busy));
    chk({tag, ".done"},     32'(d),  32'(e.done));
    chk({tag, ".step_idx"}, 32'(i),  32'(e.idx));
  endtask

  task automatic chk_main(input string tag, input obs_t e);
    chk_vals(tag, bus.btn_out, bus.busy, bus.done, bus.step_idx, e);
  endtask

  task automatic wr(input int a, input logic [2:0] m, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = 4'(a); bus.wr_mask = m; bus.wr_dur = d;
    tick();
    bus.wr_en = 1'b0;
    m_mask[a] = m; m_dur[a] = d;
  endtask

  task automatic wr4(input int a, input logic [2:0] m, input logic [7:0] d);
    bus4.wr_en = 1'b1; bus4.wr_addr = 2'(a); bus4.wr_mask = m; bus4.wr_dur = d;
    tick();
    bus4.wr_en = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      m_mask[i] = 3'b000; m_dur[i] = 16'd0;
    end
  endtask

  // Expected cycle-by-cycle outputs after start, from the script rules alone.
  task automatic build_trace(input int stop_k);
    int i;
    exp_q.delete();
    i = 0;
    while (i < DEPTH) begin
      if (m_dur[i] == 16'd0) break;
      repeat (int'(m_dur[i])) exp_q.push_back(mk(m_mask[i], 1'b1, 1'b0, 4'(i)));
      i++;
    end
    exp_q.push_back(mk(3'b000, 1'b0, 1'b1, 4'd0));
    exp_q.push_back(mk(3'b000, 1'b0, 1'b0, 4'd0));
    exp_q.push_back(mk(3'b000, 1'b0, 1'b0, 4'd0));
    for (int k = stop_k; k < exp_q.size(); k++) exp_q[k] = mk(3'b000, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic play(input int stop_k, input string tag);
    build_trace(stop_k);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      chk_main(tag, exp_q[k]);
      bus.stop = (k + 1 == stop_k);
      if (k + 1 < exp_q.size()) tick();
    end
    bus.stop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    obs_t idle_o;
    obs_t done_o;
    idle_o = mk(3'b000, 1'b0, 1'b0, 4'd0);
    done_o = mk(3'b000, 1'b0, 1'b1, 4'd0);
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0; bus.wr_en = 1'b0;
    bus.wr_addr = 4'd0; bus.wr_mask = 3'b000; bus.wr_dur = 16'd0; bus.live_btn = 3'b000;
    bus4.start = 1'b0; bus4.stop = 1'b0; bus4.loop_en = 1'b0; bus4.wr_en = 1'b0;
    bus4.wr_addr = 2'd0; bus4.wr_mask = 3'b000; bus4.wr_dur = 8'd0; bus4.live_btn = 3'b000;
    clear_model();

    // Reset state
    repeat (2) tick();
    chk_main("reset_hold", idle_o);
    rst_n = 1'b1;
    tick();
    chk_main("reset_after", idle_o);

    // T1 and T4 as a vector table
    wr(0, 3'b100, 16'd5);
    wr(1, 3'b010, 16'd3);
    wr(2, 3'b111, 16'd0);
    tbl.push_back(mv(1'b1, 1'b0, mk(3'b100, 1'b1, 1'b0, 4'd0)));
    for (int i = 0; i < 4; i++) tbl.push_back(mv(1'b0, 1'b0, mk(3'b100, 1'b1, 1'b0, 4'd0)));
    for (int i = 0; i < 3; i++) tbl.push_back(mv(1'b0, 1'b0, mk(3'b010, 1'b1, 1'b0, 4'd1)));
    tbl.push_back(mv(1'b0, 1'b0, done_o));
    tbl.push_back(mv(1'b0, 1'b0, idle_o));
    tbl.push_back(mv(1'b1, 1'b0, mk(3'b100, 1'b1, 1'b0, 4'd0)));
    tbl.push_back(mv(1'b1, 1'b0, mk(3'b100, 1'b1, 1'b0, 4'd0)));
    tbl.push_back(mv(1'b0, 1'b0, mk(3'b100, 1'b1, 1'b0, 4'd0)));
    tbl.push_back(mv(1'b0, 1'b1, idle_o));
    tbl.push_back(mv(1'b0, 1'b0, idle_o));
    tbl.push_back(mv(1'b1, 1'b1, idle_o));
    tbl.push_back(mv(1'b0, 1'b0, idle_o));
    for (int v = 0; v < tbl.size(); v++) begin
      bus.start = tbl[v].start;
      bus.stop  = tbl[v].stop;
      tick();
      chk_main($sformatf("tbl[%0d]", v), tbl[v].exp);
    end
    bus.start = 1'b0; bus.stop = 1'b0;

    // T2: looping, then drop loop_en during the third pass
    bus.loop_en = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int p = 0; p < 26; p++) begin
      if (p < 24) e = ((p % 8) < 5) ? mk(3'b100, 1'b1, 1'b0, 4'd0) : mk(3'b010, 1'b1, 1'b0, 4'd1);
      else if (p == 24) e = done_o;
      else e = idle_o;
      chk_main($sformatf("t2_loop[%0d]", p), e);
      if (p == 17) bus.loop_en = 1'b0;
      if (p < 25) tick();
    end

    // T3: TICK_DIV=4 instance, two ticks hold eight cycles
    wr4(0, 3'b001, 8'd2);
    wr4(1, 3'b000, 8'd0);
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int p = 0; p < 10; p++) begin
      if (p < 8) e = mk(3'b001, 1'b1, 1'b0, 4'd0);
      else if (p == 8) e = done_o;
      else e = idle_o;
      chk_vals($sformatf("t3_div4[%0d]", p), bus4.btn_out, bus4.busy, bus4.done,
               4'(bus4.step_idx), e);
      if (p < 9) tick();
    end

    // T5: every entry dur=1, then empty script, then async reset mid-HOLD
    for (int i = 0; i < DEPTH; i++) wr(i, 3'($urandom_range(0, 7)), 16'd1);
    play(1000, "t5_full");
    wr(0, 3'b101, 16'd0);
    play(1000, "t5_empty");
    wr(0, 3'b111, 16'd10);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 chk_main("t5_async_rst", idle_o);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    tick();
    chk_main("t5_post_rst", idle_o);
    play(1000, "t5_cleared");

    // Randomized scripts with an occasional mid-run stop
    for (int it = 0; it < 40; it++) begin
      for (int a = 0; a < DEPTH; a++) begin
        logic [15:0] d;
        d = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
        if (a == 0 && $urandom_range(0, 7) != 0 && d == 16'd0) d = 16'd2;
        wr(a, 3'($urandom_range(0, 7)), d);
      end
      play(int'($urandom_range(1, 90)), $sformatf("rnd%0d", it));
    end

`ifdef SCRIPT_LIVE_OR_EN
    // T6: live buttons merged after the synchronizer
    bus.live_btn = 3'b010;
    tick();
    chk_main("t6_idle_1", idle_o);
    tick();
    chk_main("t6_idle_2", mk(3'b010, 1'b0, 1'b0, 4'd0));
    bus.live_btn = 3'b000;
    repeat (2) tick();
    wr(0, 3'b100, 16'd10);
    wr(1, 3'b000, 16'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_main("t6_play_0", mk(3'b100, 1'b1, 1'b0, 4'd0));
    bus.live_btn = 3'b010;
    tick();
    chk_main("t6_play_1", mk(3'b100, 1'b1, 1'b0, 4'd0));
    tick();
    chk_main("t6_play_2", mk(3'b110, 1'b1, 1'b0, 4'd0));
    bus.live_btn = 3'b000;
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    repeat (2) tick();
    chk_main("t6_stop", idle_o);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
